// File: rtl/rx_elastic_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_elastic_buffer_if
// Brief    : Symbol, read-request and status bundle around the RX elastic buffer.
// Revision : 1.0
// ============================================================================
interface rx_elastic_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [7:0]       In_Data;
  logic             In_K;
  logic             In_Decode_Error;
  logic             In_Disparity_Error;
  logic             In_Valid;
  logic             Rd_En;

  logic [7:0]       Out_Data;
  logic             Out_K;
  logic             Out_Valid;
  logic             Decode_Error;
  logic             Disparity_Error;
  logic             Overflow;
  logic             Underflow;
  logic             Skp_Added;
  logic             Skp_Removed;
  logic [CNT_W-1:0] Fill_Level;

  modport master (
    output In_Data, In_K, In_Decode_Error, In_Disparity_Error, In_Valid, Rd_En,
    input  Out_Data, Out_K, Out_Valid, Decode_Error, Disparity_Error,
           Overflow, Underflow, Skp_Added, Skp_Removed, Fill_Level
  );

  modport slave (
    input  In_Data, In_K, In_Decode_Error, In_Disparity_Error, In_Valid, Rd_En,
    output Out_Data, Out_K, Out_Valid, Decode_Error, Disparity_Error,
           Overflow, Underflow, Skp_Added, Skp_Removed, Fill_Level
  );
endinterface
`default_nettype wire

// File: rtl/rx_elastic_buffer.sv
`default_nettype none
// ============================================================================
// Module   : rx_elastic_buffer
// Brief    : Single-clock RX elastic buffer with SKP insertion/removal re-centring.
// Revision : 1.0
// ============================================================================
module rx_elastic_buffer #(
  parameter int         DEPTH   = 16,
  parameter int         NOMINAL = 8,
  parameter int         HIGH_WM = 12,
  parameter int         LOW_WM  = 4,
  parameter logic [7:0] SKP_SYM = 8'h1C,
  parameter logic [7:0] COM_SYM = 8'hBC
) (
  input wire                CLK,
  input wire                Reset,
  rx_elastic_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] c_depth   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_nominal = CNT_W'(NOMINAL);
  localparam logic [CNT_W-1:0] c_high_wm = CNT_W'(HIGH_WM);
  localparam logic [CNT_W-1:0] c_low_wm  = CNT_W'(LOW_WM);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e           state_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [2:0]       skp_run_q;
  logic             dup_pending_q;

  // Entry layout: {dec_err, disp_err, K, data[7:0]}
  logic [10:0]      mem_q [DEPTH];

  logic [7:0]       out_data_q;
  logic             out_k_q;
  logic             out_valid_q;
  logic             dec_err_q;
  logic             disp_err_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             skp_added_q;
  logic             skp_removed_q;

  logic [10:0]      w_head;
  logic             w_in_skp;
  logic             w_head_skp;
  logic             w_run;
  logic             w_read;
  logic             w_rd_empty;
  logic             w_insert;
  logic             w_adv;
  logic             w_remove;
  logic             w_full_drop;
  logic             w_wr;

  assign w_head     = mem_q[rd_ptr_q];
  assign w_in_skp   = bus.In_K && (bus.In_Data == SKP_SYM);
  assign w_head_skp = w_head[8] && (w_head[7:0] == SKP_SYM);

  // The read that completes the fill is already served, so data flows on the next cycle.
  assign w_run      = (state_q == ST_RUN) || (count_q >= c_nominal);
  assign w_read     = w_run && bus.Rd_En;
  assign w_rd_empty = w_read && (count_q == '0);

  // Duplicate a lone head SKP when running dry; the advancing second copy carries Skp_Added.
  assign w_insert   = w_read && !w_rd_empty && w_head_skp &&
                      (count_q < c_low_wm) && !dup_pending_q;
  assign w_adv      = w_read && !w_rd_empty && !w_insert;

  assign w_remove    = bus.In_Valid && w_in_skp && (skp_run_q != 3'd0) &&
                       (count_q > c_high_wm);
  assign w_full_drop = bus.In_Valid && !w_remove && (count_q == c_depth) && !w_adv;
  assign w_wr        = bus.In_Valid && !w_remove && !w_full_drop;

  always_comb begin
    count_d = count_q;
    case ({w_wr, w_adv})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= {bus.In_Decode_Error, bus.In_Disparity_Error, bus.In_K, bus.In_Data};
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q  <= '0;
      count_q   <= '0;
      skp_run_q <= '0;
    end else begin
      count_q <= count_d;
      if (w_wr) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (bus.In_Valid) begin
        if (!w_in_skp) begin
          skp_run_q <= '0;
        end else if (skp_run_q != 3'd7) begin
          skp_run_q <= skp_run_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q       <= ST_FILL;
      rd_ptr_q      <= '0;
      dup_pending_q <= 1'b0;
      out_data_q    <= '0;
      out_k_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      dec_err_q     <= 1'b0;
      disp_err_q    <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      skp_added_q   <= 1'b0;
      skp_removed_q <= 1'b0;
    end else begin
      out_valid_q   <= 1'b0;
      underflow_q   <= 1'b0;
      skp_added_q   <= 1'b0;
      overflow_q    <= w_full_drop;
      skp_removed_q <= w_remove;

      if (w_rd_empty) begin
        state_q    <= ST_FILL;
        out_data_q <= '0;
        out_k_q    <= 1'b0;
        dec_err_q  <= 1'b0;
        disp_err_q <= 1'b0;
        underflow_q <= 1'b1;
      end else if (w_read) begin
        state_q       <= ST_RUN;
        out_valid_q   <= 1'b1;
        out_data_q    <= w_head[7:0];
        out_k_q       <= w_head[8];
        disp_err_q    <= w_head[9];
        dec_err_q     <= w_head[10];
        skp_added_q   <= dup_pending_q;
        dup_pending_q <= w_insert;
        if (w_adv) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
      end else if (w_run) begin
        state_q <= ST_RUN;
      end
    end
  end

  assign bus.Out_Data        = out_data_q;
  assign bus.Out_K           = out_k_q;
  assign bus.Out_Valid       = out_valid_q;
  assign bus.Decode_Error    = dec_err_q;
  assign bus.Disparity_Error = disp_err_q;
  assign bus.Overflow        = overflow_q;
  assign bus.Underflow       = underflow_q;
  assign bus.Skp_Added       = skp_added_q;
  assign bus.Skp_Removed     = skp_removed_q;
  assign bus.Fill_Level      = count_q;

  a_add_vs_underflow: assert property (@(posedge CLK) disable iff (Reset)
    !(skp_added_q && underflow_q));
  a_remove_vs_overflow: assert property (@(posedge CLK) disable iff (Reset)
    !(skp_removed_q && overflow_q));
  a_count_bound: assert property (@(posedge CLK) disable iff (Reset)
    count_q <= c_depth);

endmodule
`default_nettype wire

// File: tb/tb_rx_elastic_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_elastic_buffer
// Brief    : Directed self-checking bench for rx_elastic_buffer.
// Revision : 1.0
// ============================================================================
module tb_rx_elastic_buffer;
  logic CLK;
  logic Reset;
  int   checks;
  int   errors;

  rx_elastic_buffer_if #(.DEPTH(16)) bus ();

  rx_elastic_buffer #(
    .DEPTH(16), .NOMINAL(8), .HIGH_WM(12), .LOW_WM(4),
    .SKP_SYM(8'h1C), .COM_SYM(8'hBC)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic k, input logic [7:0] d,
                       input logic de, input logic pe, input logic rd);
    bus.In_Valid           = v;
    bus.In_K               = k;
    bus.In_Data            = d;
    bus.In_Decode_Error    = de;
    bus.In_Disparity_Error = pe;
    bus.Rd_En              = rd;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 0);
    tick();
    tick();
    checks++;
    if (bus.Out_Valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid: got %b expected 0", bus.Out_Valid);
    end
    checks++;
    if (bus.Fill_Level !== 5'd0) begin
      errors++; $display("FAIL reset_fill: got %0d expected 0", bus.Fill_Level);
    end
    checks++;
    if ({bus.Out_Data, bus.Out_K, bus.Decode_Error, bus.Disparity_Error} !== 11'd0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", bus.Out_Data);
    end
    checks++;
    if ({bus.Overflow, bus.Underflow, bus.Skp_Added, bus.Skp_Removed} !== 4'b0000) begin
      errors++; $display("FAIL reset_pulses: got %b expected 0000",
                         {bus.Overflow, bus.Underflow, bus.Skp_Added, bus.Skp_Removed});
    end
    Reset = 1'b0;
  endtask

  // Continuous write+read: first output on the cycle after the fill reaches 8.
  task automatic test_fill_in_order();
    logic [7:0] d;
    logic [7:0] exp_d;
    for (int k = 1; k <= 20; k++) begin
      d = 8'(16 + k - 1);
      drive(1, 0, d, 0, 0, 1);
      tick();
      checks++;
      if (bus.Out_Valid !== (k > 8)) begin
        errors++; $display("FAIL fill_valid[%0d]: got %b expected %b", k, bus.Out_Valid, (k > 8));
      end
      checks++;
      if (bus.Fill_Level !== ((k <= 8) ? 5'(k) : 5'd8)) begin
        errors++; $display("FAIL fill_level[%0d]: got %0d", k, bus.Fill_Level);
      end
      if (k > 8) begin
        exp_d = 8'(16 + k - 9);
        checks++;
        if (bus.Out_Data !== exp_d) begin
          errors++; $display("FAIL fill_data[%0d]: got %h expected %h", k, bus.Out_Data, exp_d);
        end
      end
      checks++;
      if ({bus.Overflow, bus.Underflow, bus.Skp_Added, bus.Skp_Removed} !== 4'b0000) begin
        errors++; $display("FAIL fill_pulses[%0d]: got %b expected 0000", k,
                           {bus.Overflow, bus.Underflow, bus.Skp_Added, bus.Skp_Removed});
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_d;
    for (int j = 0; j < 8; j++) begin
      drive(1, 0, 8'(8'h24 + j), 0, 0, 0);
      tick();
      if (j == 0) begin
        checks++;
        if (bus.Out_Valid !== 1'b0 || bus.Out_Data !== 8'h1B) begin
          errors++; $display("FAIL hold_data: got v=%b d=%h expected v=0 d=1b",
                             bus.Out_Valid, bus.Out_Data);
        end
      end
    end
    checks++;
    if (bus.Fill_Level !== 5'd16) begin
      errors++; $display("FAIL full_level: got %0d expected 16", bus.Fill_Level);
    end
    drive(1, 0, 8'h55, 0, 0, 0);
    tick();
    checks++;
    if (bus.Overflow !== 1'b1 || bus.Fill_Level !== 5'd16) begin
      errors++; $display("FAIL overflow: got ovf=%b fill=%0d expected 1/16",
                         bus.Overflow, bus.Fill_Level);
    end
    drive(0, 0, 8'h00, 0, 0, 0);
    tick();
    checks++;
    if (bus.Overflow !== 1'b0) begin
      errors++; $display("FAIL overflow_pulse: got %b expected 0", bus.Overflow);
    end
    drive(0, 0, 8'h00, 0, 0, 1);
    for (int j = 0; j < 16; j++) begin
      tick();
      exp_d = 8'(8'h1C + j);
      checks++;
      if (bus.Out_Valid !== 1'b1 || bus.Out_K !== 1'b0 || bus.Out_Data !== exp_d ||
          bus.Fill_Level !== 5'(15 - j)) begin
        errors++; $display("FAIL drain[%0d]: got v=%b d=%h fill=%0d expected v=1 d=%h fill=%0d",
                           j, bus.Out_Valid, bus.Out_Data, bus.Fill_Level, exp_d, 15 - j);
      end
    end
  endtask

  task automatic test_underflow();
    drive(0, 0, 8'h00, 0, 0, 1);
    tick();
    checks++;
    if (bus.Underflow !== 1'b1 || bus.Out_Valid !== 1'b0 || bus.Out_Data !== 8'h00 ||
        bus.Fill_Level !== 5'd0) begin
      errors++; $display("FAIL underflow: got uf=%b v=%b d=%h expected 1/0/00",
                         bus.Underflow, bus.Out_Valid, bus.Out_Data);
    end
    tick();
    checks++;
    if (bus.Underflow !== 1'b0 || bus.Out_Valid !== 1'b0) begin
      errors++; $display("FAIL underflow_once: got uf=%b v=%b expected 0/0",
                         bus.Underflow, bus.Out_Valid);
    end
    for (int j = 0; j < 8; j++) begin
      drive(1, 0, 8'(8'h60 + j), 0, 0, 1);
      tick();
      checks++;
      if (bus.Out_Valid !== 1'b0) begin
        errors++; $display("FAIL refill_quiet[%0d]: got %b expected 0", j, bus.Out_Valid);
      end
    end
    drive(0, 0, 8'h00, 0, 0, 1);
    tick();
    checks++;
    if (bus.Out_Valid !== 1'b1 || bus.Out_Data !== 8'h60 || bus.Fill_Level !== 5'd7) begin
      errors++; $display("FAIL refill_first: got v=%b d=%h fill=%0d expected 1/60/7",
                         bus.Out_Valid, bus.Out_Data, bus.Fill_Level);
    end
    drive(0, 0, 8'h00, 0, 0, 0);
    tick();
  endtask

  task automatic test_skp_remove();
    logic [7:0] exp_fill [5];
    logic       exp_rm   [5];
    logic       exp_k    [5];
    logic [7:0] exp_d    [5];
    exp_k    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_d    = '{8'hBC, 8'h1C, 8'h1C, 8'h1C, 8'h00};
    exp_fill = '{8'd14, 8'd15, 8'd15, 8'd15, 8'd15};
    exp_rm   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int j = 0; j < 6; j++) begin
      drive(1, 0, 8'(8'h70 + j), 0, 0, 0);
      tick();
    end
    checks++;
    if (bus.Fill_Level !== 5'd13) begin
      errors++; $display("FAIL skp_prefill: got %0d expected 13", bus.Fill_Level);
    end
    for (int j = 0; j < 5; j++) begin
      drive(j < 4, exp_k[j], exp_d[j], 0, 0, 0);
      tick();
      checks++;
      if (bus.Skp_Removed !== exp_rm[j] || bus.Overflow !== 1'b0 ||
          bus.Fill_Level !== 5'(exp_fill[j])) begin
        errors++; $display("FAIL skp_remove[%0d]: got rm=%b ovf=%b fill=%0d expected rm=%b fill=%0d",
                           j, bus.Skp_Removed, bus.Overflow, bus.Fill_Level, exp_rm[j], exp_fill[j]);
      end
    end
    drive(0, 0, 8'h00, 0, 0, 1);
    for (int j = 0; j < 3; j++) tick();
    drive(1, 1, 8'h1C, 0, 0, 0);
    tick();
    checks++;
    if (bus.Skp_Removed !== 1'b0 || bus.Fill_Level !== 5'd13) begin
      errors++; $display("FAIL skp_keep_at_high: got rm=%b fill=%0d expected 0/13",
                         bus.Skp_Removed, bus.Fill_Level);
    end
  endtask

  task automatic test_skp_insert();
    logic [7:0] wd   [8];
    logic       wk   [8];
    logic [7:0] ed   [10];
    logic       ek   [10];
    logic       ev   [10];
    logic       ea   [10];
    logic       eu   [10];
    logic [4:0] ef   [10];
    wd = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h1C, 8'h1C, 8'h86, 8'h87};
    wk = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ed = '{8'h80, 8'h81, 8'h82, 8'h83, 8'h1C, 8'h1C, 8'h1C, 8'h86, 8'h87, 8'h00};
    ek = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ev = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    ea = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    eu = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ef = '{5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd3, 5'd2, 5'd1, 5'd0, 5'd0};
    Reset = 1'b1;
    drive(0, 0, 8'h00, 0, 0, 0);
    tick();
    Reset = 1'b0;
    for (int j = 0; j < 8; j++) begin
      drive(1, wk[j], wd[j], 0, 0, 0);
      tick();
    end
    drive(0, 0, 8'h00, 0, 0, 1);
    for (int j = 0; j < 10; j++) begin
      tick();
      checks++;
      if (bus.Out_Valid !== ev[j] || bus.Out_Data !== ed[j] || bus.Out_K !== ek[j] ||
          bus.Skp_Added !== ea[j] || bus.Underflow !== eu[j] || bus.Fill_Level !== ef[j]) begin
        errors++; $display("FAIL skp_insert[%0d]: got v=%b d=%h k=%b add=%b uf=%b fill=%0d expected v=%b d=%h k=%b add=%b uf=%b fill=%0d",
                           j, bus.Out_Valid, bus.Out_Data, bus.Out_K, bus.Skp_Added, bus.Underflow,
                           bus.Fill_Level, ev[j], ed[j], ek[j], ea[j], eu[j], ef[j]);
      end
    end
  endtask

  task automatic test_error_flags();
    logic [7:0] ed [3];
    logic       ee [3];
    logic       ep [3];
    ed = '{8'h90, 8'h91, 8'h92};
    ee = '{1'b1, 1'b0, 1'b0};
    ep = '{1'b0, 1'b0, 1'b1};
    for (int j = 0; j < 8; j++) begin
      drive(1, 0, 8'(8'h90 + j), (j == 0), (j == 2), 0);
      tick();
    end
    drive(0, 0, 8'h00, 0, 0, 1);
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++;
      if (bus.Out_Data !== ed[j] || bus.Decode_Error !== ee[j] || bus.Disparity_Error !== ep[j]) begin
        errors++; $display("FAIL err_flags[%0d]: got d=%h de=%b pe=%b expected d=%h de=%b pe=%b",
                           j, bus.Out_Data, bus.Decode_Error, bus.Disparity_Error, ed[j], ee[j], ep[j]);
      end
    end
    Reset = 1'b1;
    #1;
    checks++;
    if ({bus.Out_Valid, bus.Out_Data, bus.Disparity_Error} !== 10'd0 || bus.Fill_Level !== 5'd0) begin
      errors++; $display("FAIL async_reset: got v=%b d=%h pe=%b fill=%0d expected all 0",
                         bus.Out_Valid, bus.Out_Data, bus.Disparity_Error, bus.Fill_Level);
    end
    tick();
    Reset = 1'b0;
    tick();
    checks++;
    if (bus.Out_Valid !== 1'b0 || bus.Underflow !== 1'b0 || bus.Fill_Level !== 5'd0) begin
      errors++; $display("FAIL post_reset: got v=%b uf=%b fill=%0d expected 0/0/0",
                         bus.Out_Valid, bus.Underflow, bus.Fill_Level);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill_in_order();
    test_overflow();
    test_underflow();
    test_skp_remove();
    test_skp_insert();
    test_error_flags();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
